// File: rtl/qkv_spikes_reader_if.sv
// Output stream of the Q/K/V spike reader: one {V,K,Q} line per beat,
// transferred on a cycle where o_qkv_valid and i_qkv_ready are both high.
interface qkv_spikes_reader_if #(
  parameter int DATA_W = 128
);
  logic [3*DATA_W-1:0] o_qkv_data;
  logic                o_qkv_valid;
  logic                i_qkv_ready;

  modport master (
    output o_qkv_data,
    output o_qkv_valid,
    input  i_qkv_ready
  );

  modport slave (
    input  o_qkv_data,
    input  o_qkv_valid,
    output i_qkv_ready
  );
endinterface

// File: rtl/qkv_spikes_reader.sv
// Read-side sequencer for the Q/K/V spike-line RAM group.
// Waits for the RAM group to hold a full set, walks the three RAMs in lockstep
// and absorbs the BRAM read latency in a small FIFO. Reads are issued only
// while FIFO occupancy plus reads still in flight leave room, so no line is
// lost when the downstream stalls.
//
// Optional feature: define QKV_RD_LOOP_EN to make one job run PASSES full
// passes over the address range before draining.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no job; address holds its last value
// WAIT_RDY | job accepted, waiting for the RAM group ready flag
// READ     | issuing one read per cycle while FIFO credit allows
// DRAIN    | all addresses issued; waiting for in-flight reads and FIFO to empty
module qkv_spikes_reader #(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 768,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PASSES     = 2
) (
  input  logic                s_clk,
  input  logic                s_rst,
  input  logic                i_SpikesTmpRam_Ready,
  input  logic                i_start,
  output logic [ADDR_W-1:0]   o_QueryRam_rdaddr,
  input  logic [DATA_W-1:0]   i_QueryRam_out,
  output logic [ADDR_W-1:0]   o_KeyRam_rdaddr,
  input  logic [DATA_W-1:0]   i_KeyRam_out,
  output logic [ADDR_W-1:0]   o_ValueRam_rdaddr,
  input  logic [DATA_W-1:0]   i_ValueRam_out,
  qkv_spikes_reader_if.master stream_o,
  output logic                o_busy,
  output logic                o_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // The FIFO must cover the read pipeline plus one beat of slack for full rate.
  if (RD_LAT < 1 || RD_LAT > 2 || FIFO_DEPTH < RD_LAT + 2 || PASSES < 1) begin : g_bad_cfg
    $error("qkv_spikes_reader: unsupported RD_LAT/FIFO_DEPTH/PASSES combination");
  end

  typedef enum logic [1:0] {IDLE, WAIT_RDY, READ, DRAIN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                busy_q;
  logic [RD_LAT-1:0]   tag_q;
  logic [3*DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    inflight;
  logic                credit_ok;
  logic                issue;
  logic                push;
  logic                pop;
  logic                drain_done;

`ifdef QKV_RD_LOOP_EN
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);
  logic [PASS_W-1:0] pass_q;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Count reads issued but not yet written into the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(tag_q[i]);
    end
  end

  assign credit_ok  = ((CNT_W+1)'(count_q) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue      = (state_q == READ) && credit_ok;
  assign push       = tag_q[RD_LAT-1];
  assign pop        = stream_o.o_qkv_valid && stream_o.i_qkv_ready;
  assign drain_done = (state_q == DRAIN) && (inflight == '0) && (count_q == '0);

  assign o_QueryRam_rdaddr   = addr_q;
  assign o_KeyRam_rdaddr     = addr_q;
  assign o_ValueRam_rdaddr   = addr_q;
  assign stream_o.o_qkv_valid = (count_q != '0);
  assign stream_o.o_qkv_data  = mem_q[rd_ptr_q];
  assign o_busy              = busy_q;
  assign o_done              = drain_done;

  // Job sequencing and read-address generation.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
`ifdef QKV_RD_LOOP_EN
      pass_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= WAIT_RDY;
            busy_q  <= 1'b1;
            addr_q  <= '0;
`ifdef QKV_RD_LOOP_EN
            pass_q  <= '0;
`endif
          end
        end
        WAIT_RDY: begin
          if (i_SpikesTmpRam_Ready) begin
            state_q <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (addr_q == LAST_ADDR) begin
`ifdef QKV_RD_LOOP_EN
              if (pass_q == LAST_PASS) begin
                state_q <= DRAIN;
              end else begin
                addr_q <= '0;
                pass_q <= pass_q + 1'b1;
              end
`else
              state_q <= DRAIN;
`endif
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-latency tags and FIFO occupancy/pointers.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_q <= (tag_q << 1) | RD_LAT'(issue);
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge s_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_ValueRam_out, i_KeyRam_out, i_QueryRam_out};
    end
  end

endmodule

// File: tb/tb_qkv_spikes_reader.sv
// Directed bench for qkv_spikes_reader with a 1-cycle-latency RAM model.
// Q/K/V words differ per RAM so lane swaps show up in the data checks.
module tb_qkv_spikes_reader;
  localparam int DATA_W     = 128;
  localparam int DEPTH      = 768;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 4;
`ifdef QKV_RD_LOOP_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int NBEATS = DEPTH * NPASS;

  logic              s_clk = 1'b0;
  logic              s_rst;
  logic              ram_rdy;
  logic              start;
  logic [ADDR_W-1:0] q_addr, k_addr, v_addr;
  logic [DATA_W-1:0] q_out, k_out, v_out;
  logic              busy, done;
  int                n_vec = 0;
  int                n_err = 0;

  qkv_spikes_reader_if #(.DATA_W(DATA_W)) stream ();

  qkv_spikes_reader #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .RD_LAT(1), .FIFO_DEPTH(FIFO_DEPTH), .PASSES(2)
  ) dut (
    .s_clk                (s_clk),
    .s_rst                (s_rst),
    .i_SpikesTmpRam_Ready (ram_rdy),
    .i_start              (start),
    .o_QueryRam_rdaddr    (q_addr),
    .i_QueryRam_out       (q_out),
    .o_KeyRam_rdaddr      (k_addr),
    .i_KeyRam_out         (k_out),
    .o_ValueRam_rdaddr    (v_addr),
    .i_ValueRam_out       (v_out),
    .stream_o             (stream),
    .o_busy               (busy),
    .o_done               (done)
  );

  always #5 s_clk = ~s_clk;

  // Synchronous-read RAMs: word(a) = a, a+0x1000, a+0x2000 for Q, K, V.
  always_ff @(posedge s_clk) begin
    q_out <= DATA_W'(q_addr);
    k_out <= DATA_W'(k_addr) + DATA_W'(32'h1000);
    v_out <= DATA_W'(v_addr) + DATA_W'(32'h2000);
  end

  function automatic logic [3*DATA_W-1:0] exp_word(input int a);
    logic [DATA_W-1:0] q;
    q = DATA_W'(a);
    return {q + DATA_W'(32'h2000), q + DATA_W'(32'h1000), q};
  endfunction

  task automatic chk(input string tag, input logic [3*DATA_W-1:0] obs, input logic [3*DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives i_qkv_ready each cycle and checks every accepted beat in order.
  task automatic run_stream(input int mode, input int stall_at, input int stall_len, input int abort_at,
                            output int beats, output int dones, output int cf, output int cl,
                            output int maxa, output bit fin);
    int                  stall_cnt;
    int                  addr0;
    logic [3*DATA_W-1:0] held;
    logic                rdy;
    beats = 0; dones = 0; cf = -1; cl = -1; maxa = 0; fin = 1'b0;
    stall_cnt = 0; addr0 = 0; held = '0;
    for (int c = 0; c < 20000; c++) begin
      if (done) dones++;
      if (abort_at >= 0 && beats == abort_at) begin
        fin = 1'b1;
        return;
      end
      if (dones > 0 && !busy) begin
        fin = 1'b1;
        return;
      end
      if (int'(q_addr) > maxa) maxa = int'(q_addr);
      if (stall_at >= 0 && beats == stall_at && stall_cnt < stall_len) begin
        rdy = 1'b0;
        if (stall_cnt == 0) begin
          held  = stream.o_qkv_data;
          addr0 = int'(q_addr);
          chk("stall_valid", stream.o_qkv_valid, 1);
        end else begin
          chk("stall_hold", stream.o_qkv_data, held);
        end
        stall_cnt++;
        if (stall_cnt == stall_len)
          chk("stall_addr_bound", (int'(q_addr) - addr0 <= FIFO_DEPTH), 1);
      end else if (mode == 1) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      stream.i_qkv_ready = rdy;
      if (stream.o_qkv_valid && rdy) begin
        chk("beat_data", stream.o_qkv_data, exp_word(beats % DEPTH));
        if (cf < 0) cf = c;
        cl = c;
        beats++;
      end
      @(negedge s_clk);
    end
  endtask

  initial begin
    int beats, dones, cf, cl, maxa, late_done, late_valid;
    bit fin;
    s_rst = 1'b1; ram_rdy = 1'b0; start = 1'b0; stream.i_qkv_ready = 1'b0;
    repeat (3) @(negedge s_clk);
    s_rst = 1'b0;
    @(negedge s_clk);
    chk("rst_valid", stream.o_qkv_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_qaddr", q_addr, 0);
    chk("rst_kaddr", k_addr, 0);
    chk("rst_vaddr", v_addr, 0);

    // Full-rate job: first beat three cycles after the start pulse is sampled.
    ram_rdy = 1'b1; stream.i_qkv_ready = 1'b1; start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    chk("t1_busy", busy, 1);
    repeat (2) @(negedge s_clk);
    chk("t1_lat_early", stream.o_qkv_valid, 0);
    @(negedge s_clk);
    chk("t1_lat_first", stream.o_qkv_valid, 1);
    run_stream(0, -1, 0, -1, beats, dones, cf, cl, maxa, fin);
    chk("t1_finish", fin, 1);
    chk("t1_beats", beats, NBEATS);
    chk("t1_done_once", dones, 1);
    chk("t1_contiguous", cl - cf, NBEATS - 1);
    chk("t1_max_addr", maxa, DEPTH - 1);
    chk("t1_end_addr", q_addr, DEPTH - 1);
    chk("t1_end_busy", busy, 0);
    chk("t1_end_valid", stream.o_qkv_valid, 0);

    // Start while the RAM group is not ready: nothing issues until it is.
    ram_rdy = 1'b0; start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    repeat (50) @(negedge s_clk);
    chk("t2_wait_addr", q_addr, 0);
    chk("t2_wait_valid", stream.o_qkv_valid, 0);
    chk("t2_wait_busy", busy, 1);
    ram_rdy = 1'b1;
    @(negedge s_clk);
    chk("t2_addr_first", q_addr, 0);
    @(negedge s_clk);
    chk("t2_addr_go", q_addr, 1);
    run_stream(0, -1, 0, -1, beats, dones, cf, cl, maxa, fin);
    chk("t2_finish", fin, 1);
    chk("t2_beats", beats, NBEATS);
    chk("t2_done_once", dones, 1);

    // Random backpressure.
    start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    run_stream(1, -1, 0, -1, beats, dones, cf, cl, maxa, fin);
    chk("t3_finish", fin, 1);
    chk("t3_beats", beats, NBEATS);
    chk("t3_done_once", dones, 1);
    chk("t3_max_addr", maxa, DEPTH - 1);

    // 100-cycle stall at beat 200.
    start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    run_stream(0, 200, 100, -1, beats, dones, cf, cl, maxa, fin);
    chk("t4_finish", fin, 1);
    chk("t4_beats", beats, NBEATS);
    chk("t4_done_once", dones, 1);

    // Reset at beat 300, then a clean restart.
    start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    run_stream(0, -1, 0, 300, beats, dones, cf, cl, maxa, fin);
    chk("t5_reached_abort", beats, 300);
    s_rst = 1'b1;
    @(negedge s_clk);
    chk("t5_rst_valid", stream.o_qkv_valid, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", q_addr, 0);
    s_rst = 1'b0;
    late_done = 0; late_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge s_clk);
      if (done) late_done++;
      if (stream.o_qkv_valid) late_valid++;
    end
    chk("t5_no_done", late_done, 0);
    chk("t5_no_valid", late_valid, 0);
    start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    run_stream(0, -1, 0, -1, beats, dones, cf, cl, maxa, fin);
    chk("t5_finish", fin, 1);
    chk("t5_beats", beats, NBEATS);
    chk("t5_done_once", dones, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
